dram_write_serializer: RTL and testbench
========================================

# dram_write_serializer

Downstream receiver for the SIMD pipeline's `dramwd` vector-write stream. Joins each VSIZE-lane write vector with its address/lane-mask from the address generator, buffers up to DEPTH joined vectors, and serializes them into narrower masked DRAM write beats. Beats whose lane-mask slice is all zero are never issued. Sits between the ALU pipeline output and the DRAM write port of the tile.

## Interface

Parameters:
- VSIZE, 32, lanes per vector (power of 2).
- DBW, 16, bits per lane.
- GBW, 32, DRAM word-address width.
- BLANES, 8, lanes per DRAM beat; VSIZE % BLANES == 0; NB = VSIZE/BLANES.
- DEPTH, 4, joined-vector FIFO entries (power of 2, ≥2).

Ports. One clock; reset is synchronous and active-high:
- i_clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- dramwd_rdy, in, 1, write vector valid.
- dramwd_ack, out, 1, write vector accepted.
- i_dramwd, in, DBW×[VSIZE], write vector data.
- dramwa_rdy, in, 1, address valid.
- dramwa_ack, out, 1, address accepted.
- i_dramwa_addr, in, GBW, word address of lane 0.
- i_dramwa_mask, in, VSIZE, per-lane write enable (bit i = lane i).
- dramw_rdy, out, 1, DRAM beat valid.
- dramw_ack, in, 1, DRAM beat accepted.
- o_dramw_addr, out, GBW, word address of beat lane 0.
- o_dramw_data, out, DBW×[BLANES], beat data.
- o_dramw_mask, out, BLANES, beat lane enables.
- o_idle, out, 1, FIFO empty and no beat pending.

## Operation

- rdy/ack rule: a transfer occurs on a cycle with rdy && ack. The sender holds rdy and payload stable until ack.
- Join: dramwd_ack = dramwa_ack = dramwd_rdy && dramwa_rdy && (count < DEPTH) && !i_rst. Both inputs are consumed in the same cycle, or neither is. A lone rdy on one side waits indefinitely.
- The push decision uses the pre-pop count. A full FIFO does not accept on the same cycle as a pop.
- The FIFO stores {addr, mask, data}. A head beat index bidx (0..NB-1) tracks progress within the head entry.
- Beat k covers lanes k·BLANES .. k·BLANES+BLANES-1, at address addr + k·BLANES (mod 2^GBW, wraps silently).
- Load condition: output register empty (!dramw_rdy) or being acked (dramw_rdy && dramw_ack), and count > 0.
- When the load condition holds, search the head entry for the lowest k ≥ bidx with nonzero mask slice:
  - Found: load the beat into the output register and set dramw_rdy=1. If no nonzero slice > k exists, pop the head and set bidx=0. Otherwise set bidx=k+1.
  - Not found (e.g. all-zero mask): pop the head, set bidx=0, and load nothing (dramw_rdy=0 unless reloaded next cycle).
- If the output register is acked and the load condition finds nothing to load, dramw_rdy drops to 0.
- o_idle = (count==0) && !dramw_rdy.

## Timing

- Reset (sync, i_rst=1 at posedge) sets: count=0, rd/wr pointers=0, bidx=0, dramw_rdy=0, o_dramw_addr/data/mask=0, o_idle=1. The acks are forced 0 while i_rst is high.
- Reset mid-burst discards all buffered vectors and the pending beat without issuing anything further.
- Latency: for a vector accepted at cycle T into an empty FIFO with an idle output, the first beat has dramw_rdy=1 at T+1.
- Throughput with dramw_ack held high: one beat per cycle, back-to-back across entries with no bubble.
- Each all-zero-mask entry costs exactly one bubble cycle.
- Backpressure: while dramw_rdy && !dramw_ack, the output register, bidx and the FIFO head are frozen.
- Pushes continue until count==DEPTH.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- dramw_rdy, o_dramw_*, and o_idle are registered. The acks are combinational from the rdy inputs and count.

## Test plan

- Single vector, addr=0x100, mask all ones, VSIZE=32, BLANES=8, dramw_ack=1 → 4 beats on consecutive cycles at addr 0x100, 0x108, 0x110, 0x118, each mask 0xFF, data = matching lane slices. o_idle returns to 1 the cycle after the last ack.
- Sparse mask 0x00FF_0F00 → exactly 2 beats: addr+8 with mask 0x0F, then addr+16 with mask 0xFF. The entry pops with the second beat.
- All-zero-mask vector followed by a full-mask vector, ack=1 → no beat for the first vector, one bubble cycle, then 4 beats for the second.
- dramw_ack=0 with 6 vectors offered → exactly 4 accepted (DEPTH) and dramwd_ack=0 after that. Releasing ack drains 16 beats in order, and the remaining 2 vectors are then accepted.
- dramwd_rdy raised 3 cycles before dramwa_rdy → both acks stay 0 until both rdy are high, then both pulse in the same cycle.
- Assert i_rst during the 2nd beat of a 4-beat vector with another vector queued → next cycle dramw_rdy=0 and o_idle=1. Nothing further is issued, and new input is accepted normally after reset deasserts.

Source files
------------

// File: rtl/dram_write_serializer.sv
// Purpose: joins dramwd vectors with their address/lane-mask, queues them, and emits masked DRAM write beats.
// Latency: a vector accepted on edge T into an empty queue shows its first beat (dramw_rdy=1) after edge T+1.
// Backpressure: a stalled beat freezes the output register, beat index and queue head; inputs stall when full.
//
// Ports:
//   i_clk, i_rst                                  clock, synchronous active-high reset
//   dramwd_rdy/dramwd_ack, i_dramwd               write-vector handshake and VSIZE x DBW lane data
//   dramwa_rdy/dramwa_ack, i_dramwa_addr/_mask    address handshake, lane-0 word address, per-lane enables
//   dramw_rdy/dramw_ack, o_dramw_addr/_data/_mask registered DRAM beat: address of beat lane 0, BLANES lanes, enables
//   o_idle                                        registered: queue empty and no beat pending

// Small generic synchronous FIFO. Head is read combinationally from storage.
// Latency: a push is visible at the head one cycle later.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module wsr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_vld) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !rst) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module dram_write_serializer #(
  parameter int VSIZE  = 32,
  parameter int DBW    = 16,
  parameter int GBW    = 32,
  parameter int BLANES = 8,
  parameter int DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          dramwd_rdy,
  output logic                          dramwd_ack,
  input  logic [VSIZE-1:0][DBW-1:0]     i_dramwd,
  input  logic                          dramwa_rdy,
  output logic                          dramwa_ack,
  input  logic [GBW-1:0]                i_dramwa_addr,
  input  logic [VSIZE-1:0]              i_dramwa_mask,
  output logic                          dramw_rdy,
  input  logic                          dramw_ack,
  output logic [GBW-1:0]                o_dramw_addr,
  output logic [BLANES-1:0][DBW-1:0]    o_dramw_data,
  output logic [BLANES-1:0]             o_dramw_mask,
  output logic                          o_idle
);
  localparam int NB = VSIZE / BLANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [GBW-1:0]            addr;
    logic [VSIZE-1:0]          mask;
    logic [VSIZE-1:0][DBW-1:0] data;
  } entry_t;

  entry_t                     push_dat;
  entry_t                     head;
  logic [CW-1:0]              count;
  logic [CW-1:0]              count_nxt;
  logic                       push_vld;
  logic                       pop;
  logic                       load_ok;
  logic                       found;
  logic                       more;
  logic [BW-1:0]              kidx;
  logic [BW-1:0]              bidx;
  logic [GBW-1:0]             beat_addr;
  logic [BLANES-1:0][DBW-1:0] beat_data;
  logic [BLANES-1:0]          beat_mask;
  logic                       rdy_nxt;
  logic                       idle_nxt;

  // Both sides are consumed together; the full check uses the pre-pop count.
  assign push_vld   = dramwd_rdy && dramwa_rdy && (count < CW'(DEPTH)) && !i_rst;
  assign dramwd_ack = push_vld;
  assign dramwa_ack = push_vld;
  assign push_dat   = '{addr: i_dramwa_addr, mask: i_dramwa_mask, data: i_dramwd};

  wsr_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .count    (count)
  );

  // Lowest non-empty slice at or after bidx, and whether any later one remains.
  always_comb begin
    found = 1'b0;
    more  = 1'b0;
    kidx  = '0;
    for (int j = 0; j < NB; j++) begin
      if (j >= int'(bidx) && head.mask[j*BLANES +: BLANES] != '0) begin
        if (!found) begin
          found = 1'b1;
          kidx  = BW'(j);
        end else begin
          more = 1'b1;
        end
      end
    end
  end

  assign load_ok   = (!dramw_rdy || dramw_ack) && (count != '0);
  // The head leaves when its last live beat is loaded, or at once if nothing is left.
  assign pop       = load_ok && (!found || !more);
  assign beat_addr = head.addr + GBW'(int'(kidx) * BLANES);
  assign beat_data = head.data[int'(kidx)*BLANES +: BLANES];
  assign beat_mask = head.mask[int'(kidx)*BLANES +: BLANES];

  assign rdy_nxt   = load_ok ? found : (dramw_rdy && !dramw_ack);
  assign count_nxt = count + CW'(push_vld) - CW'(pop);
  assign idle_nxt  = (count_nxt == '0) && !rdy_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dramw_rdy    <= 1'b0;
      bidx         <= '0;
      o_dramw_addr <= '0;
      o_dramw_data <= '0;
      o_dramw_mask <= '0;
      o_idle       <= 1'b1;
    end else begin
      dramw_rdy <= rdy_nxt;
      o_idle    <= idle_nxt;
      if (load_ok) begin
        if (found) begin
          o_dramw_addr <= beat_addr;
          o_dramw_data <= beat_data;
          o_dramw_mask <= beat_mask;
          bidx         <= more ? (kidx + BW'(1)) : '0;
        end else begin
          bidx <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dram_write_serializer.sv
// Bench for dram_write_serializer: directed scenarios plus randomized traffic.
// The reference model expands every accepted vector into its expected beat list
// and the beat stream is compared in order against it.
module tb_dram_write_serializer;
  localparam int VSIZE = 32, DBW = 16, GBW = 32, BLANES = 8, DEPTH = 4, NB = VSIZE / BLANES;

  typedef logic [VSIZE-1:0][DBW-1:0]  vec_t;
  typedef logic [BLANES-1:0][DBW-1:0] bdat_t;
  typedef struct packed {
    logic [GBW-1:0]    addr;
    logic [BLANES-1:0] mask;
    bdat_t             data;
  } beat_t;

  logic              i_clk;
  logic              i_rst;
  logic              dramwd_rdy, dramwd_ack;
  vec_t              i_dramwd;
  logic              dramwa_rdy, dramwa_ack;
  logic [GBW-1:0]    i_dramwa_addr;
  logic [VSIZE-1:0]  i_dramwa_mask;
  logic              dramw_rdy, dramw_ack;
  logic [GBW-1:0]    o_dramw_addr;
  bdat_t             o_dramw_data;
  logic [BLANES-1:0] o_dramw_mask;
  logic              o_idle;

  int    total = 0;
  int    bad = 0;
  int    beats_seen = 0;
  int    ack_mode = 0;  // 0: hold dramw_ack low, 1: hold high, 2: random
  beat_t exp_q[$];

  dram_write_serializer #(
    .VSIZE(VSIZE), .DBW(DBW), .GBW(GBW), .BLANES(BLANES), .DEPTH(DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .dramwd_rdy(dramwd_rdy), .dramwd_ack(dramwd_ack), .i_dramwd(i_dramwd),
    .dramwa_rdy(dramwa_rdy), .dramwa_ack(dramwa_ack),
    .i_dramwa_addr(i_dramwa_addr), .i_dramwa_mask(i_dramwa_mask),
    .dramw_rdy(dramw_rdy), .dramw_ack(dramw_ack),
    .o_dramw_addr(o_dramw_addr), .o_dramw_data(o_dramw_data), .o_dramw_mask(o_dramw_mask),
    .o_idle(o_idle)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beats of one vector: every lane group with a nonzero mask, lowest first.
  task automatic model_push(input logic [GBW-1:0] a, input logic [VSIZE-1:0] m, input vec_t d);
    beat_t b;
    for (int k = 0; k < NB; k++) begin
      if (m[k*BLANES +: BLANES] != '0) begin
        b.addr = a + GBW'(k * BLANES);
        b.mask = m[k*BLANES +: BLANES];
        b.data = d[k*BLANES +: BLANES];
        exp_q.push_back(b);
      end
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    case (ack_mode)
      0:       dramw_ack = 1'b0;
      1:       dramw_ack = 1'b1;
      default: dramw_ack = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: handshakes are evaluated mid-cycle, ahead of the edge that commits them.
  always @(negedge i_clk) begin
    beat_t e;
    if (i_rst) begin
      exp_q.delete();
    end else begin
      if (!(dramwd_rdy && dramwa_rdy)) begin
        chk("ack_without_join_d", dramwd_ack, 0);
        chk("ack_without_join_a", dramwa_ack, 0);
      end
      if (dramwd_ack || dramwa_ack) chk("ack_pair", {dramwd_ack, dramwa_ack}, 2'b11);
      if (dramwd_rdy && dramwa_rdy && dramwd_ack && dramwa_ack)
        model_push(i_dramwa_addr, i_dramwa_mask, i_dramwd);
      if (dramw_rdy && dramw_ack) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          chk("beat_unexpected_qsize", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", o_dramw_addr, e.addr);
          chk("beat_mask", o_dramw_mask, e.mask);
          chk("beat_data", o_dramw_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VSIZE; i++) v[i] = DBW'($urandom);
    return v;
  endfunction

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [GBW-1:0] a, input logic [VSIZE-1:0] m, input vec_t d);
    int n = 0;
    i_dramwa_addr = a;
    i_dramwa_mask = m;
    i_dramwd      = d;
    dramwd_rdy    = 1'b1;
    dramwa_rdy    = 1'b1;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(dramwd_ack && dramwa_ack) && n < 500);
    chk("send_accept", dramwd_ack, 1);
    tick();
    dramwd_rdy = 1'b0;
    dramwa_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(o_idle && exp_q.size() == 0) && n < 3000);
    chk({tag, "_idle"}, o_idle, 1);
    chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    logic [VSIZE-1:0] m;
    int               base_beats;
    int               n;

    i_rst = 1'b1;
    dramwd_rdy = 1'b1;  // acks must stay low during reset even with both sides ready
    dramwa_rdy = 1'b1;
    i_dramwd = '0;
    i_dramwa_addr = '0;
    i_dramwa_mask = '1;
    dramw_ack = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_rdy", dramw_rdy, 0);
    chk("rst_idle", o_idle, 1);
    chk("rst_addr", o_dramw_addr, 0);
    chk("rst_mask", o_dramw_mask, 0);
    chk("rst_data", o_dramw_data, 0);
    chk("rst_wd_ack", dramwd_ack, 0);
    chk("rst_wa_ack", dramwa_ack, 0);
    tick();
    i_rst = 1'b0;
    dramwd_rdy = 1'b0;
    dramwa_rdy = 1'b0;

    // Single full vector: latency, four consecutive beats, idle afterwards.
    @(negedge i_clk);
    ack_mode = 1;
    tick();
    send(32'h100, '1, rand_vec());
    @(negedge i_clk);
    chk("lat_first_cycle_rdy", dramw_rdy, 0);
    for (int i = 0; i < NB; i++) begin
      @(negedge i_clk);
      chk("full_rdy", dramw_rdy, 1);
      chk("full_addr", o_dramw_addr, 32'h100 + 32'(i * BLANES));
      chk("full_mask", o_dramw_mask, 8'hFF);
    end
    @(negedge i_clk);
    chk("full_after_rdy", dramw_rdy, 0);
    chk("full_after_idle", o_idle, 1);
    tick();

    // Sparse mask: only lane groups 1 and 2 carry enables.
    send(32'h2000, 32'h00FF_0F00, rand_vec());
    @(negedge i_clk);
    @(negedge i_clk);
    chk("sparse_b0_rdy", dramw_rdy, 1);
    chk("sparse_b0_addr", o_dramw_addr, 32'h2008);
    chk("sparse_b0_mask", o_dramw_mask, 8'h0F);
    @(negedge i_clk);
    chk("sparse_b1_rdy", dramw_rdy, 1);
    chk("sparse_b1_addr", o_dramw_addr, 32'h2010);
    chk("sparse_b1_mask", o_dramw_mask, 8'hFF);
    @(negedge i_clk);
    chk("sparse_end_rdy", dramw_rdy, 0);
    chk("sparse_end_idle", o_idle, 1);
    tick();

    // Zero-mask vector then a full one: the zero entry yields no beat, only a bubble.
    send(32'h3000, '0, rand_vec());
    send(32'h4000, '1, rand_vec());
    @(negedge i_clk);
    chk("zero_bubble_rdy", dramw_rdy, 0);
    for (int i = 0; i < NB; i++) begin
      @(negedge i_clk);
      chk("zero_next_rdy", dramw_rdy, 1);
      chk("zero_next_addr", o_dramw_addr, 32'h4000 + 32'(i * BLANES));
    end
    wait_idle("zero");

    // Backpressure: only DEPTH vectors fit while the output is stalled.
    @(negedge i_clk);
    ack_mode = 0;
    tick();
    base_beats = beats_seen;
    for (int i = 0; i < DEPTH; i++) send(32'h5000 + 32'(i * 64), '1, rand_vec());
    i_dramwa_addr = 32'h5100;
    i_dramwa_mask = '1;
    i_dramwd = rand_vec();
    dramwd_rdy = 1'b1;
    dramwa_rdy = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("full_wd_ack", dramwd_ack, 0);
      chk("full_wa_ack", dramwa_ack, 0);
      chk("full_stall_rdy", dramw_rdy, 1);
      chk("full_stall_addr", o_dramw_addr, 32'h5000);
    end
    ack_mode = 1;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!dramwd_ack && n < 100);
    chk("fifth_accept", dramwd_ack, 1);
    tick();
    dramwd_rdy = 1'b0;
    dramwa_rdy = 1'b0;
    send(32'h5140, '1, rand_vec());
    wait_idle("bp");
    chk("bp_beat_count", 32'(beats_seen - base_beats), 32'(6 * NB));

    // Skewed handshake: data side ready three cycles before the address side.
    i_dramwa_addr = 32'h5800;
    i_dramwa_mask = 32'h0000_00FF;
    i_dramwd = rand_vec();
    dramwd_rdy = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("skew_wd_ack", dramwd_ack, 0);
      chk("skew_wa_ack", dramwa_ack, 0);
    end
    tick();
    dramwa_rdy = 1'b1;
    @(negedge i_clk);
    chk("skew_join_wd_ack", dramwd_ack, 1);
    chk("skew_join_wa_ack", dramwa_ack, 1);
    tick();
    dramwd_rdy = 1'b0;
    dramwa_rdy = 1'b0;
    wait_idle("skew");

    // Reset during the second beat with another vector queued.
    send(32'h6000, '1, rand_vec());
    send(32'h7000, '1, rand_vec());
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(dramw_rdy && o_dramw_addr == 32'h6000) && n < 50);
    chk("rst_first_beat_seen", o_dramw_addr, 32'h6000);
    tick();
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_second_beat_addr", o_dramw_addr, 32'h6008);
    tick();
    i_rst = 1'b0;
    base_beats = beats_seen;
    @(negedge i_clk);
    chk("midrst_rdy", dramw_rdy, 0);
    chk("midrst_idle", o_idle, 1);
    chk("midrst_mask", o_dramw_mask, 0);
    repeat (5) begin
      @(negedge i_clk);
      chk("midrst_quiet_rdy", dramw_rdy, 0);
    end
    tick();
    chk("midrst_nothing_issued", 32'(beats_seen - base_beats), 32'd0);
    send(32'h8000, 32'h0000_FFFF, rand_vec());
    wait_idle("postrst");
    chk("postrst_beat_count", 32'(beats_seen - base_beats), 32'd2);

    // Randomized traffic with random DRAM backpressure and address wrap.
    @(negedge i_clk);
    ack_mode = 2;
    tick();
    for (int v = 0; v < 150; v++) begin
      repeat ($urandom_range(0, 2)) tick();
      case ($urandom_range(0, 4))
        0: m = '0;
        1: m = '1;
        2: m = VSIZE'($urandom);
        default: begin
          m = '0;
          for (int k = 0; k < NB; k++)
            if ($urandom_range(0, 1) == 1) m[k*BLANES +: BLANES] = BLANES'($urandom_range(1, 255));
        end
      endcase
      send(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : 32'($urandom),
           m, rand_vec());
    end
    @(negedge i_clk);
    ack_mode = 1;
    tick();
    wait_idle("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
